// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: MD opcodes,
// default latencies and small opcode classification helpers.
package mult_div_unit_pkg;

    localparam int MUL_LAT_DEFAULT = 5;
    localparam int DIV_LAT_DEFAULT = 10;
    localparam int CNT_W_DEFAULT   = 4;

    // Codes 3'd6 and 3'd7 are left undefined and cause no state change.
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_latency_counter.sv
// Down-counter that sets how long the MD unit stays busy; done marks the
// last busy cycle, on whose closing edge the result is written.
module md_latency_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);
    assign done = (count == CNT_W'(1));

endmodule

// File: rtl/mult_div_unit.sv
// E-stage HI/LO multiply/divide unit. Operands are latched on accept and
// the 64-bit result is computed combinationally, then written at done.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT,
    parameter int DIV_LAT = DIV_LAT_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic             accept;
    logic             mul_start;
    logic             div_start;
    logic [CNT_W-1:0] load_val;
    logic             done;

    logic [31:0]      a_q;
    logic [31:0]      b_q;
    md_op_e           op_q;

    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic             div_ovf;
    logic             div_zero;
    logic [31:0]      b_safe;
    logic [31:0]      quot_s;
    logic [31:0]      rem_s;
    logic [31:0]      quot_u;
    logic [31:0]      rem_u;

    logic             res_we;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;

    // A start while busy is dropped; the hazard unit never issues one then.
    assign accept    = start & ~busy;
    assign mul_start = accept & is_mul_op(md_op);
    assign div_start = accept & is_div_op(md_op);
    assign load_val  = mul_start ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);

    md_latency_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (mul_start | div_start),
        .load_val(load_val),
        .busy    (busy),
        .done    (done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= MD_MULT;
        end else if (mul_start | div_start) begin
            a_q  <= op_a;
            b_q  <= op_b;
            op_q <= md_op_e'(md_op);
        end
    end

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // The divider never sees a zero or overflowing divisor; those cases are
    // resolved explicitly in the result mux below.
    assign div_zero = (b_q == 32'd0);
    assign div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    assign b_safe   = (div_zero || div_ovf) ? 32'd1 : b_q;
    assign quot_s   = $signed(a_q) / $signed(b_safe);
    assign rem_s    = $signed(a_q) % $signed(b_safe);
    assign quot_u   = a_q / b_safe;
    assign rem_u    = a_q % b_safe;

    always_comb begin
        res_we = 1'b0;
        res_hi = '0;
        res_lo = '0;
        case (op_q)
            MD_MULT: begin
                res_we          = 1'b1;
                {res_hi, res_lo} = prod_s;
            end
            MD_MULTU: begin
                res_we          = 1'b1;
                {res_hi, res_lo} = prod_u;
            end
            MD_DIV: begin
                res_we = !div_zero;
                if (div_ovf) begin
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = rem_s;
                    res_lo = quot_s;
                end
            end
            MD_DIVU: begin
                res_we = !div_zero;
                res_hi = rem_u;
                res_lo = quot_u;
            end
            default: begin
                res_we = 1'b0;
            end
        endcase
    end

    // MTHI/MTLO only land while idle, so they never collide with done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi <= '0;
            lo <= '0;
        end else if (accept && (md_op == MD_MTHI)) begin
            hi <= op_a;
        end else if (accept && (md_op == MD_MTLO)) begin
            lo <= op_a;
        end else if (done && res_we) begin
            hi <= res_hi;
            lo <= res_lo;
        end
    end

endmodule
